note_slot_arbiter: RTL and testbench
====================================

# note_slot_arbiter

Allocates incoming MIDI note events to the two wave-generator frequency slots consumed by `physics` (`freq_id1`, `freq_id2`, `new_f_in`). It sits between the `midi` receiver and `physics`. Note-on/note-off events are resolved into a shadow slot table using free-slot-first, then least-recently-used replacement. The shadow table is committed to the outputs only on a frame boundary (rising `vsync`), so the displayed wave never changes mid-frame.

## Interface
- `KEY_BASE`, default 48: MIDI key index that maps to `freq_id` 0.
- `NUM_FREQ`, default 32: number of valid frequency ids; keys in `[KEY_BASE, KEY_BASE+NUM_FREQ-1]` are in range.
- `clock`  in  1: 65 MHz system clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `midi_ready`  in  1: one-cycle strobe; `key_on` and `key_index` are valid this cycle.
- `key_on`  in  1: 1 means note-on, 0 means note-off.
- `key_index`  in  7: MIDI key number.
- `vsync`  in  1: active-high VGA vsync from `xvga`.
- `freq_id1`, `freq_id2`  out  5: committed frequency id of slot 0 and slot 1.
- `active`  out  2: committed slot-valid bits; bit 0 is slot 0.
- `new_freq`  out  1: one-cycle pulse when the committed slot state changed.
- `dropped`  out  1: one-cycle pulse when an out-of-range key is rejected.

## Operation
- **Shadow state:** `sh_id[0..1]` (5b each), `sh_act[1:0]`, and a 1-bit `lru` pointer naming the least-recently-used slot.
- **Event pipeline:** a 1-entry event register captures `{key_on, key_index}` on `midi_ready`. The event is resolved on the following cycle (state RESOLVE). FSM states are IDLE and RESOLVE, and the block returns to IDLE after one cycle.
- **Range check:** `id = key_index - KEY_BASE`, computed at 8-bit width. If the key is outside the range, no state changes, `dropped` pulses, and the block goes to IDLE.
- **Note-on, in priority order:**
  - (a) The key already occupies an active slot s: set `lru = ~s`; no id change.
  - (b) Otherwise, the lowest-numbered inactive slot s is loaded with `id`, `sh_act[s]=1`, and `lru = ~s`.
  - (c) Otherwise, slot `lru` is overwritten with `id` and `lru` toggles.
- **Note-off:** every active slot whose id matches is cleared. Clearing sets `sh_act=0` and keeps the stale `sh_id`. `lru` is set to the slot just freed (one matched slot), or is unchanged if no slot matched.
- **Commit:** `vs_q` registers `vsync`, and `vs_rise = vsync & ~vs_q`. On `vs_rise`, `{freq_id1, freq_id2, active}` load from shadow.
  - If the shadow differs from the current outputs, `new_freq` pulses that same cycle.
  - Inactive slots present `freq_id = 0` at the outputs.
- **Events arriving back-to-back:** `midi_ready` in the RESOLVE cycle is captured into the event register and resolved next cycle. Throughput is therefore 1 event per cycle with no loss.
- **Simultaneous resolve and `vs_rise`:** the commit takes the shadow value before the resolve. That event appears at the next frame.

## Timing
- **Reset (async assert, sync release):** `freq_id1 = freq_id2 = 0`, `active = 0`, `new_freq = 0`, `dropped = 0`, shadow cleared, `lru = 0`, `vs_q = 0`, FSM in IDLE.
- **Event to shadow:** 2 cycles, i.e. `midi_ready` at cycle t updates the shadow at the edge ending t+1.
- **Event to output:** the first `vs_rise` detected at or after cycle t+2. Outputs and `new_freq` change on the edge ending the `vs_rise` cycle.
- **`dropped`:** asserted during cycle t+1, one cycle wide.
- **`new_freq`:** never wider than 1 cycle, and at most once per frame.
- **`vsync` held high:** commits once only; it must fall before it can re-arm.
- **`reset_n` mid-frame or mid-event:** any pending event is discarded and the outputs return to reset values immediately.

## Configuration
- **`NOTE_SLOT_RELEASE_EN` defined:** note-off events free slots as described in Operation.
- **`NOTE_SLOT_RELEASE_EN` undefined:** `key_on` is ignored and every event is treated as a note-on.
  - Once filled, slots are only replaced via LRU, never freed.
  - The `active` bits only ever rise until reset.

## Test plan
- **Reset then single event:** reset, `midi_ready` with key 50 on, then `vsync` pulse. Expect `freq_id1 = 2`, `active = 01`, one `new_freq` pulse, `freq_id2 = 0`.
- **LRU replacement:** keys 48, 52, 60 on, then `vsync`. Expect slot0 = 12, slot1 = 4, `active = 11`, `lru = 1`.
- **Out of range:** keys 47 and 80 on. Expect a `dropped` pulse at t+1 for each, no shadow change, and no `new_freq` at the next `vsync`.
- **Frame gating:** key 55 on, resolved in the same cycle as `vs_rise`. Expect outputs unchanged that frame and `freq_id1 = 7` at the next `vs_rise`.
- **Release (`NOTE_SLOT_RELEASE_EN` defined):** keys 48 and 52 on, key 48 off, then `vsync`. Expect `active = 10`, `freq_id1 = 0`, `freq_id2 = 4`. A subsequent key 49 on loads slot0 with 1.
- **Async reset mid-event:** assert `reset_n = 0` the cycle after `midi_ready`. Expect all outputs 0 immediately, and no commit at the following `vsync`.

Source files
------------

// File: rtl/note_slot_arbiter.sv
// note_slot_arbiter: resolves MIDI note events into a two-slot shadow table
// (free slot first, then least-recently-used replacement) and commits the
// table to the wave-generator outputs only on a rising vsync.
// Optional feature macro: NOTE_SLOT_RELEASE_EN. When defined, note-off events
// free matching slots; when undefined, key_on is ignored and every event is a
// note-on, so slots are only ever replaced, never freed.
`timescale 1ns/1ps
module note_slot_arbiter #(
   parameter int KEY_BASE = 48,
   parameter int NUM_FREQ = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       midi_ready,
   input  logic       key_on,
   input  logic [6:0] key_index,
   input  logic       vsync,
   output logic [4:0] freq_id1,
   output logic [4:0] freq_id2,
   output logic [1:0] active,
   output logic       new_freq,
   output logic       dropped
);

   localparam logic [7:0] BASE8 = 8'(KEY_BASE);
   localparam logic [7:0] NUM8  = 8'(NUM_FREQ);

   typedef enum logic {IDLE = 1'b0, RESOLVE = 1'b1} state_t;

   // A key is usable when it lies in [KEY_BASE, KEY_BASE+NUM_FREQ-1].
   function automatic logic key_in_range(input logic [6:0] key);
      logic [7:0] ext;
      ext = {1'b0, key};
      return (ext >= BASE8) && ((ext - BASE8) < NUM8);
   endfunction

   state_t     state_r;
   logic [6:0] ev_key_r;
   logic [4:0] sh_id0_r;
   logic [4:0] sh_id1_r;
   logic [1:0] sh_act_r;
   logic       lru_r;
   logic       vs_q_r;

`ifdef NOTE_SLOT_RELEASE_EN
   logic       ev_on_r;
`else
   logic       unused_key_on_s;
   assign unused_key_on_s = key_on;
`endif

   logic       in_range_s;
   logic       on_s;
   logic [4:0] id_s;
   logic       hit0_s;
   logic       hit1_s;
   logic [4:0] nx_id0_s;
   logic [4:0] nx_id1_s;
   logic [1:0] nx_act_s;
   logic       nx_lru_s;

   logic       vs_rise_s;
   logic [4:0] pr_id0_s;
   logic [4:0] pr_id1_s;
   logic       changed_s;

   // next shadow table for the event held in the event register
   always_comb begin
      in_range_s = key_in_range(ev_key_r);
      // low five bits of (key - base) are the frequency id
      id_s       = ev_key_r[4:0] - BASE8[4:0];
`ifdef NOTE_SLOT_RELEASE_EN
      on_s       = ev_on_r;
`else
      on_s       = 1'b1;
`endif
      hit0_s     = sh_act_r[0] && (sh_id0_r == id_s);
      hit1_s     = sh_act_r[1] && (sh_id1_r == id_s);
      nx_id0_s   = sh_id0_r;
      nx_id1_s   = sh_id1_r;
      nx_act_s   = sh_act_r;
      nx_lru_s   = lru_r;
      if ((state_r == RESOLVE) && in_range_s) begin
         if (on_s) begin
            if (hit0_s) begin
               nx_lru_s = 1'b1;
            end else if (hit1_s) begin
               nx_lru_s = 1'b0;
            end else if (!sh_act_r[0]) begin
               nx_id0_s    = id_s;
               nx_act_s[0] = 1'b1;
               nx_lru_s    = 1'b1;
            end else if (!sh_act_r[1]) begin
               nx_id1_s    = id_s;
               nx_act_s[1] = 1'b1;
               nx_lru_s    = 1'b0;
            end else if (lru_r == 1'b0) begin
               nx_id0_s = id_s;
               nx_lru_s = 1'b1;
            end else begin
               nx_id1_s = id_s;
               nx_lru_s = 1'b0;
            end
         end else begin
            // release keeps the stale id; the freed slot becomes the LRU one
            if (hit0_s) begin
               nx_act_s[0] = 1'b0;
               nx_lru_s    = 1'b0;
            end else if (hit1_s) begin
               nx_act_s[1] = 1'b0;
               nx_lru_s    = 1'b1;
            end else begin
               nx_lru_s = lru_r;
            end
         end
      end else begin
         nx_lru_s = lru_r;
      end
   end

   // commit view of the shadow table and frame-edge detect
   always_comb begin
      vs_rise_s = vsync & ~vs_q_r;
      pr_id0_s  = sh_act_r[0] ? sh_id0_r : 5'd0;
      pr_id1_s  = sh_act_r[1] ? sh_id1_r : 5'd0;
      changed_s = ({pr_id0_s, pr_id1_s, sh_act_r} != {freq_id1, freq_id2, active});
   end

   // event FSM: capture, resolve into the shadow table, flag rejected keys
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         ev_key_r <= 7'd0;
`ifdef NOTE_SLOT_RELEASE_EN
         ev_on_r  <= 1'b0;
`endif
         sh_id0_r <= 5'd0;
         sh_id1_r <= 5'd0;
         sh_act_r <= 2'b00;
         lru_r    <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         sh_id0_r <= nx_id0_s;
         sh_id1_r <= nx_id1_s;
         sh_act_r <= nx_act_s;
         lru_r    <= nx_lru_s;
         // flag the rejection in the cycle the event is being resolved
         dropped  <= midi_ready && !key_in_range(key_index);
         case (state_r)
            IDLE, RESOLVE: begin
               if (midi_ready) begin
                  ev_key_r <= key_index;
`ifdef NOTE_SLOT_RELEASE_EN
                  ev_on_r  <= key_on;
`endif
                  state_r  <= RESOLVE;
               end else begin
                  state_r  <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // frame-boundary commit of the shadow table to the outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vs_q_r   <= 1'b0;
         freq_id1 <= 5'd0;
         freq_id2 <= 5'd0;
         active   <= 2'b00;
         new_freq <= 1'b0;
      end else begin
         vs_q_r <= vsync;
         if (vs_rise_s) begin
            freq_id1 <= pr_id0_s;
            freq_id2 <= pr_id1_s;
            active   <= sh_act_r;
            new_freq <= changed_s;
         end else begin
            new_freq <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_note_slot_arbiter.sv
// Scoreboard bench for note_slot_arbiter: a slot/timestamp reference model
// predicts each frame commit and each rejected key; a monitor compares.
`timescale 1ns/1ps
module tb_note_slot_arbiter;
   localparam int KEY_BASE = 48;
   localparam int NUM_FREQ = 32;

   logic       clock      = 1'b0;
   logic       reset_n    = 1'b1;
   logic       midi_ready = 1'b0;
   logic       key_on     = 1'b0;
   logic [6:0] key_index  = 7'd0;
   logic       vsync      = 1'b0;
   logic [4:0] freq_id1;
   logic [4:0] freq_id2;
   logic [1:0] active;
   logic       new_freq;
   logic       dropped;

   note_slot_arbiter #(.KEY_BASE(KEY_BASE), .NUM_FREQ(NUM_FREQ)) dut (
      .clock(clock), .reset_n(reset_n), .midi_ready(midi_ready),
      .key_on(key_on), .key_index(key_index), .vsync(vsync),
      .freq_id1(freq_id1), .freq_id2(freq_id2), .active(active),
      .new_freq(new_freq), .dropped(dropped));

   always #8 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct packed {
      logic [4:0] id1;
      logic [4:0] id2;
      logic [1:0] act;
      logic       nf;
   } commit_t;

   commit_t commit_q[$];
   int      drop_q[$];
   int      checks = 0;
   int      errors = 0;
   bit      mon_en = 1'b0;

   // reference model: slot contents plus last-use timestamps
   int m_id[2];
   bit m_act[2];
   int m_stamp[2];
   int m_tick;
   int m_out1, m_out2, m_outa;
   bit m_vs_prev;
   bit m_pend_v, m_pend_on;
   int m_pend_key;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_id[0] = 0; m_id[1] = 0; m_act[0] = 1'b0; m_act[1] = 1'b0;
      m_stamp[0] = -1; m_stamp[1] = 0; m_tick = 0;
      m_out1 = 0; m_out2 = 0; m_outa = 0;
      m_vs_prev = 1'b0; m_pend_v = 1'b0; m_pend_on = 1'b0; m_pend_key = 0;
   endtask

   task automatic touch(input int s);
      m_tick++;
      m_stamp[s] = m_tick;
   endtask

   task automatic model_apply(input bit on, input int key);
      int id, hit, free, victim, nmatch, last;
      if (key < KEY_BASE || key >= KEY_BASE + NUM_FREQ) return;
      id = key - KEY_BASE;
`ifndef NOTE_SLOT_RELEASE_EN
      on = 1'b1;
`endif
      if (on) begin
         hit = -1;
         for (int s = 1; s >= 0; s--) if (m_act[s] && m_id[s] == id) hit = s;
         if (hit >= 0) touch(hit);
         else begin
            free = -1;
            for (int s = 1; s >= 0; s--) if (!m_act[s]) free = s;
            if (free >= 0) begin
               m_id[free] = id; m_act[free] = 1'b1; touch(free);
            end else begin
               victim = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
               m_id[victim] = id; touch(victim);
            end
         end
      end else begin
         nmatch = 0; last = 0;
         for (int s = 0; s < 2; s++) begin
            if (m_act[s] && m_id[s] == id) begin
               m_act[s] = 1'b0; last = s; nmatch++;
            end
         end
         if (nmatch > 0) m_stamp[last] = m_stamp[1 - last] - 1;
      end
   endtask

   // one cycle of model: commit sees the table before this cycle's resolve
   task automatic model_cycle(input bit ev, input bit on, input int key, input bit vs);
      if (vs && !m_vs_prev) begin
         commit_t c;
         int e1, e2, ea;
         e1 = m_act[0] ? m_id[0] : 0;
         e2 = m_act[1] ? m_id[1] : 0;
         ea = {m_act[1], m_act[0]};
         c.id1 = 5'(e1); c.id2 = 5'(e2); c.act = 2'(ea);
         c.nf  = (e1 != m_out1) || (e2 != m_out2) || (ea != m_outa);
         m_out1 = e1; m_out2 = e2; m_outa = ea;
         commit_q.push_back(c);
      end
      m_vs_prev = vs;
      if (m_pend_v) model_apply(m_pend_on, m_pend_key);
      m_pend_v = ev; m_pend_on = on; m_pend_key = key;
      if (ev && (key < KEY_BASE || key >= KEY_BASE + NUM_FREQ)) drop_q.push_back(cyc + 1);
   endtask

   task automatic step(input bit ev, input bit on, input int key, input bit vs);
      midi_ready = ev; key_on = on; key_index = 7'(key); vsync = vs;
      model_cycle(ev, on, key, vs);
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic vs_pulse();
      step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 0, 1'b1);
      idle(2);
   endtask

   task automatic do_reset();
      midi_ready = 1'b0; vsync = 1'b0; reset_n = 1'b0;
      #1;
      chk("rst_freq_id1", freq_id1, 0);
      chk("rst_freq_id2", freq_id2, 0);
      chk("rst_active", active, 0);
      chk("rst_new_freq", new_freq, 0);
      chk("rst_dropped", dropped, 0);
      model_reset();
      commit_q.delete();
      drop_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // monitor: pops expected commits and drop strobes as the DUT presents them
   initial begin : monitor
      bit prev_vs;
      bit due;
      bit drop_now;
      commit_t c;
      prev_vs = 1'b0; due = 1'b0;
      forever begin
         @(negedge clock);
         if (!mon_en || !reset_n) begin
            prev_vs = 1'b0; due = 1'b0;
         end else begin
            if (due) begin
               if (commit_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL commit_missing no expectation at cycle %0d", cyc);
               end else begin
                  c = commit_q.pop_front();
                  chk("commit_freq_id1", freq_id1, c.id1);
                  chk("commit_freq_id2", freq_id2, c.id2);
                  chk("commit_active", active, c.act);
                  chk("commit_new_freq", new_freq, c.nf);
               end
            end else begin
               chk("new_freq_idle", new_freq, 0);
            end
            drop_now = (drop_q.size() > 0) && (drop_q[0] == cyc);
            chk("dropped", dropped, drop_now);
            if (drop_now) void'(drop_q.pop_front());
            due = vsync && !prev_vs;
            prev_vs = vsync;
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int bound[6];
      bit vs_r;
      bound[0] = 47; bound[1] = 48; bound[2] = 79; bound[3] = 80; bound[4] = 0; bound[5] = 127;
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      mon_en = 1'b1;

      // single event after reset
      step(1'b1, 1'b1, 50, 1'b0); idle(3); vs_pulse();
      // fill both slots then LRU replacement, then a second replacement
      do_reset();
      step(1'b1, 1'b1, 48, 1'b0); step(1'b1, 1'b1, 52, 1'b0); step(1'b1, 1'b1, 60, 1'b0);
      idle(2); vs_pulse();
      step(1'b1, 1'b1, 70, 1'b0); idle(2); vs_pulse();
      // out-of-range keys back to back: drop strobes, no change at commit
      step(1'b1, 1'b1, 47, 1'b0); step(1'b1, 1'b1, 80, 1'b0); idle(2); vs_pulse();
      // event resolved in the vs_rise cycle waits for the next frame
      do_reset();
      step(1'b1, 1'b1, 55, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1);
      idle(2); vs_pulse();
      // release sequence (note-off treated as note-on when release is off)
      do_reset();
      step(1'b1, 1'b1, 48, 1'b0); step(1'b1, 1'b1, 52, 1'b0); step(1'b1, 1'b0, 48, 1'b0);
      idle(2); vs_pulse();
      step(1'b1, 1'b1, 49, 1'b0); idle(2); vs_pulse();
      // reset during an event: pending event discarded, next commit stays empty
      step(1'b1, 1'b1, 57, 1'b0);
      do_reset();
      idle(2); vs_pulse();

      // randomized traffic
      vs_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit ev, on;
         int key, r;
         if ($urandom_range(0, 699) == 0) begin
            do_reset();
            vs_r = 1'b0;
         end
         ev = ($urandom_range(0, 9) < 4);
         on = ($urandom_range(0, 2) != 0);
         r  = $urandom_range(0, 9);
         if (r < 5) key = $urandom_range(48, 79);
         else if (r < 8) key = $urandom_range(48, 53);
         else key = bound[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) vs_r = ~vs_r;
         step(ev, on, key, vs_r);
      end
      idle(3); vs_pulse();
      chk("commit_queue_empty", commit_q.size(), 0);
      chk("drop_queue_empty", drop_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
